// File: rtl/redux_ctrl.sv
// Redux-V 8-bit multi-cycle controller: fetch/decode sequencer, PC, 4x8 register file,
// initiator to an external combinational ALU and master on a single-port memory bus.
module redux_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         DATA_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [3:0]        alu_Seletor,
  input  logic [DATA_W-1:0] alu_S,
  input  logic              alu_ZERO,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc,
  output logic              halted,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEMRD,
    MEMWR,
    LIRD,
    HALT
  } state_t;

  localparam logic [3:0]        OP_LD   = 4'd10;
  localparam logic [3:0]        OP_ST   = 4'd11;
  localparam logic [3:0]        OP_BRZR = 4'd12;
  localparam logic [3:0]        OP_JI   = 4'd13;
  localparam logic [3:0]        OP_LI   = 4'd14;
  localparam logic [DATA_W-1:0] ONE     = 1;

  state_t            state;
  state_t            stateNext;
  logic [DATA_W-1:0] pcReg;
  logic [DATA_W-1:0] pcNext;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] irNext;
  logic [DATA_W-1:0] rf [4];
  logic              regWe;
  logic [DATA_W-1:0] regWdata;

  logic [3:0]        op;
  logic [1:0]        ra;
  logic [1:0]        rb;
  logic [DATA_W-1:0] rfA;
  logic [DATA_W-1:0] rfB;
  logic [DATA_W-1:0] immExt;

  assign op       = ir[7:4];
  assign ra       = ir[3:2];
  assign rb       = ir[1:0];
  assign rfA      = rf[ra];
  assign rfB      = rf[rb];
  assign immExt   = {{(DATA_W-4){ir[3]}}, ir[3:0]};
  assign pc       = pcReg;
  assign halted   = (state == HALT);
  assign dbg_data = rf[dbg_sel];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pcReg <= RESET_PC;
      ir    <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      state <= stateNext;
      pcReg <= pcNext;
      ir    <= irNext;
      if (regWe) rf[ra] <= regWdata;
    end
  end

  // Bus and ALU drive depend only on state and registers, never on the returned
  // ALU result or mem_ready, so the external combinational ALU closes no loop.
  always_comb begin
    alu_A       = '0;
    alu_B       = '0;
    alu_Seletor = '0;
    mem_addr    = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_re   = 1'b1;
          mem_addr = pcReg;
        end
        EXEC: begin
          if (op == OP_BRZR) begin
            alu_A       = rfA;
            alu_B       = rfA;
            alu_Seletor = 4'd2;
          end else begin
            alu_A       = rfA;
            alu_B       = rfB;
            alu_Seletor = op;
          end
        end
        MEMRD: begin
          mem_re   = 1'b1;
          mem_addr = rfB;
        end
        MEMWR: begin
          mem_we    = 1'b1;
          mem_addr  = rfB;
          mem_wdata = rfA;
        end
        LIRD: begin
          mem_re   = 1'b1;
          mem_addr = pcReg;
        end
        default: ;
      endcase
    end
  end

  // Sequencing and write-back; every memory state stalls until mem_ready.
  always_comb begin
    stateNext = state;
    pcNext    = pcReg;
    irNext    = ir;
    regWe     = 1'b0;
    regWdata  = '0;
    case (state)
      FETCH: begin
        if (mem_ready) begin
          irNext    = mem_rdata;
          pcNext    = pcReg + ONE;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        case (op)
          OP_LD:   stateNext = MEMRD;
          OP_ST:   stateNext = MEMWR;
          OP_BRZR: stateNext = EXEC;
          OP_JI: begin
            // PC already points past the instruction; offset is from its own address.
            pcNext    = pcReg - ONE + immExt;
            stateNext = FETCH;
          end
          OP_LI:   stateNext = LIRD;
          4'd15:   stateNext = HALT;
          default: stateNext = EXEC;
        endcase
      end
      EXEC: begin
        if (op == OP_BRZR) begin
          if (alu_ZERO) pcNext = rfB;
        end else begin
          regWe    = 1'b1;
          regWdata = alu_S;
        end
        stateNext = FETCH;
      end
      MEMRD: begin
        if (mem_ready) begin
          regWe     = 1'b1;
          regWdata  = mem_rdata;
          stateNext = FETCH;
        end
      end
      MEMWR: begin
        if (mem_ready) stateNext = FETCH;
      end
      LIRD: begin
        if (mem_ready) begin
          regWe     = 1'b1;
          regWdata  = mem_rdata;
          pcNext    = pcReg + ONE;
          stateNext = FETCH;
        end
      end
      HALT: stateNext = HALT;
      default: stateNext = FETCH;
    endcase
  end

endmodule

// File: tb/tb_redux_ctrl.sv
// Self-checking bench for redux_ctrl: reference ALU, wait-state memory, table of ALU
// vectors plus hand-written program sequences for branches, jumps, waits and reset.
module tb_redux_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] alu_A, alu_B, alu_S;
  logic [3:0] alu_Seletor;
  logic       alu_ZERO;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_re, mem_we, mem_ready;
  logic [7:0] pc;
  logic       halted;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       loadMem    = 1'b0;
  int         waitCycles = 0;
  int         waitCnt    = 0;

  redux_ctrl #(.RESET_PC(8'h00), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Seletor(alu_Seletor),
    .alu_S(alu_S), .alu_ZERO(alu_ZERO),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #10 clock = ~clock;

  // Reference ALU: shifts and rotate use B[2:0] as the amount.
  always_comb begin
    logic [15:0] rot;
    rot = {alu_A, alu_A} << alu_B[2:0];
    case (alu_Seletor)
      4'd0: alu_S = ~alu_A;
      4'd1: alu_S = alu_A & alu_B;
      4'd2: alu_S = alu_A | alu_B;
      4'd3: alu_S = alu_A ^ alu_B;
      4'd4: alu_S = alu_A + alu_B;
      4'd5: alu_S = alu_A - alu_B;
      4'd6: alu_S = alu_A << alu_B[2:0];
      4'd7: alu_S = alu_A >> alu_B[2:0];
      4'd8: alu_S = 8'(alu_A * alu_B);
      4'd9: alu_S = rot[15:8];
      default: alu_S = 8'h00;
    endcase
  end
  assign alu_ZERO = (alu_S == 8'h00);

  // Memory completes each request after waitCycles stall cycles.
  assign mem_ready = (mem_re || mem_we) && (waitCnt >= waitCycles);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (loadMem) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_we && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (!(mem_re || mem_we) || mem_ready) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  int         weCycles, weRise, weBad, overlap;
  logic       prevWe;
  logic [7:0] lastA, lastB, brA;
  logic [3:0] lastSel;
  logic       lastZero, brSeen;
  logic [7:0] readLog [$];

  // Bus/ALU observer, cleared while reset is held.
  always @(negedge clock) begin
    if (reset) begin
      weCycles <= 0; weRise <= 0; weBad <= 0; overlap <= 0; prevWe <= 1'b0;
      lastA <= 8'h00; lastB <= 8'h00; lastSel <= 4'h0; brA <= 8'hFF;
      lastZero <= 1'b0; brSeen <= 1'b0;
      readLog.delete();
    end else begin
      if (mem_re && mem_we) overlap <= overlap + 1;
      if (mem_we) begin
        weCycles <= weCycles + 1;
        if (!prevWe) weRise <= weRise + 1;
        if (mem_addr !== 8'h40 || mem_wdata !== 8'hAA) weBad <= weBad + 1;
      end
      prevWe <= mem_we;
      if (mem_re && mem_ready) readLog.push_back(mem_addr);
      if (alu_A != 8'h00 || alu_B != 8'h00 || alu_Seletor != 4'h0) begin
        lastA <= alu_A; lastB <= alu_B; lastSel <= alu_Seletor;
      end
      if (alu_Seletor == 4'd2) begin
        brSeen <= 1'b1; brA <= alu_A; lastZero <= alu_ZERO;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearImage();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic setBytes(input int base, input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) img[(base + i) % 256] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic readReg(input int idx, output logic [7:0] v);
    dbg_sel = idx[1:0];
    #1;
    v = dbg_data;
  endtask

  task automatic applyStimulus(input string name, input int w);
    @(negedge clock);
    reset      = 1'b1;
    loadMem    = 1'b1;
    waitCycles = w;
    @(posedge clock);
    #1 loadMem = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput({name, " rst mem_re"}, mem_re, 0);
    checkOutput({name, " rst pc"}, pc, 8'h00);
    checkOutput({name, " rst halted"}, halted, 0);
    reset = 1'b0;
    #1;
    checkOutput({name, " first fetch addr"}, {mem_re, mem_addr}, {1'b1, 8'h00});
  endtask

  task automatic runUntilHalt(input string name, input int limit, output int cycles);
    cycles = 0;
    while (!halted && cycles < limit) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    checkOutput({name, " halted"}, halted, 1);
  endtask

  function automatic bit hasPair(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i + 1 < readLog.size(); i++)
      if (readLog[i] == a && readLog[i+1] == b) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    logic [7:0] instr;
    logic [7:0] expR0;
    logic [3:0] expSel;
    logic [7:0] expB;
  } aluVec_t;

  aluVec_t aluTab [10];

  initial begin
    int         cyc;
    logic [7:0] v;

    aluTab[0] = '{8'h00, 8'hF7, 4'd0, 8'h08};
    aluTab[1] = '{8'h11, 8'h00, 4'd1, 8'h02};
    aluTab[2] = '{8'h21, 8'h0A, 4'd2, 8'h02};
    aluTab[3] = '{8'h31, 8'h0A, 4'd3, 8'h02};
    aluTab[4] = '{8'h41, 8'h0A, 4'd4, 8'h02};
    aluTab[5] = '{8'h51, 8'h06, 4'd5, 8'h02};
    aluTab[6] = '{8'h61, 8'h20, 4'd6, 8'h02};
    aluTab[7] = '{8'h71, 8'h02, 4'd7, 8'h02};
    aluTab[8] = '{8'h81, 8'h10, 4'd8, 8'h02};
    aluTab[9] = '{8'h91, 8'h20, 4'd9, 8'h02};

    // LI R0,8; LI R1,2; ADD R0,R1; HALT
    clearImage();
    setBytes(0, 64'hE008E40241F0, 6);
    applyStimulus("add", 0);
    runUntilHalt("add", 200, cyc);
    checkOutput("add latency", cyc, 11);
    checkOutput("add alu_A", lastA, 8'h08);
    checkOutput("add alu_B", lastB, 8'h02);
    checkOutput("add sel", lastSel, 4'd4);
    readReg(0, v); checkOutput("add R0", v, 8'h0A);
    readReg(1, v); checkOutput("add R1", v, 8'h02);
    checkOutput("add pc", pc, 8'h06);
    repeat (5) @(posedge clock);
    #1;
    checkOutput("halt sticky", {halted, mem_re, mem_we, pc}, {1'b1, 1'b0, 1'b0, 8'h06});

    for (int k = 0; k < 10; k++) begin
      clearImage();
      setBytes(0, 64'hE008E402, 4);
      img[4] = aluTab[k].instr;
      img[5] = 8'hF0;
      applyStimulus($sformatf("alu%0d", k), 0);
      runUntilHalt($sformatf("alu%0d", k), 200, cyc);
      checkOutput($sformatf("alu%0d sel", k), lastSel, aluTab[k].expSel);
      checkOutput($sformatf("alu%0d A/B", k), {lastA, lastB}, {8'h08, aluTab[k].expB});
      readReg(0, v);
      checkOutput($sformatf("alu%0d R0", k), v, aluTab[k].expR0);
    end

    // R0<=5; SUB R0,R0; R2<=0x20; BRZR R0,R2 -> taken
    clearImage();
    setBytes(0, 64'hE00550E820C2F0F0, 8);
    img[8'h20] = 8'hF0;
    applyStimulus("brzr taken", 0);
    runUntilHalt("brzr taken", 200, cyc);
    checkOutput("brzr taken zero", {brSeen, lastZero, brA}, {1'b1, 1'b1, 8'h00});
    checkOutput("brzr taken pc", pc, 8'h21);
    readReg(2, v); checkOutput("brzr taken R2", v, 8'h20);

    // R0=5, branch not taken, R0 must survive
    clearImage();
    setBytes(0, 64'hE005E820C2F0, 6);
    img[8'h20] = 8'hF0;
    applyStimulus("brzr not", 0);
    runUntilHalt("brzr not", 200, cyc);
    checkOutput("brzr not zero", {brSeen, lastZero, brA}, {1'b1, 1'b0, 8'h05});
    checkOutput("brzr not pc", pc, 8'h06);
    readReg(0, v); checkOutput("brzr not R0", v, 8'h05);

    // ST R0->[0x40]; LD R2<-[0x40] with 3 wait cycles per request
    clearImage();
    setBytes(0, 64'hE440E0AAB1A9F0, 7);
    applyStimulus("stld", 3);
    runUntilHalt("stld", 400, cyc);
    checkOutput("stld latency", cyc, 41);
    checkOutput("stld mem40", mem[8'h40], 8'hAA);
    readReg(2, v); checkOutput("stld R2", v, 8'hAA);
    checkOutput("stld we cycles", weCycles, 4);
    checkOutput("stld we pulses", weRise, 1);
    checkOutput("stld we unstable", weBad, 0);
    checkOutput("stld re&we", overlap, 0);

    // LD R1<-[R1]: address taken before write-back
    clearImage();
    setBytes(0, 64'hE440A5F0, 4);
    img[8'h40] = 8'h77;
    applyStimulus("ld same", 0);
    runUntilHalt("ld same", 200, cyc);
    readReg(1, v); checkOutput("ld same R1", v, 8'h77);

    // Branch to 0x10, JI -2 lands on 0x0E
    clearImage();
    setBytes(0, 64'hE410C1, 3);
    img[8'h10] = 8'hDE;
    img[8'h0E] = 8'hF0;
    applyStimulus("ji back", 0);
    runUntilHalt("ji back", 200, cyc);
    checkOutput("ji back latency", cyc, 10);
    checkOutput("ji back fetch", hasPair(8'h10, 8'h0E), 1);
    checkOutput("ji back pc", pc, 8'h0F);

    clearImage();
    img[0] = 8'hD3;
    img[3] = 8'hF0;
    applyStimulus("ji fwd", 0);
    runUntilHalt("ji fwd", 200, cyc);
    checkOutput("ji fwd latency", cyc, 4);
    checkOutput("ji fwd pc", pc, 8'h04);

    // Jump to 0xFF; LI there wraps PC and takes its operand from 0x00
    clearImage();
    setBytes(0, 64'hE4FFC1, 3);
    img[8'hFF] = 8'hE8;
    applyStimulus("wrap", 0);
    runUntilHalt("wrap", 200, cyc);
    checkOutput("wrap fetch", hasPair(8'hFF, 8'h00), 1);
    readReg(2, v); checkOutput("wrap R2", v, 8'hE4);
    checkOutput("wrap pc", pc, 8'h02);

    // Reset during a stalled MEMWR
    clearImage();
    setBytes(0, 64'hE440E0AAB1F0, 6);
    img[8'h40] = 8'h55;
    applyStimulus("rstmid", 3);
    for (int i = 0; i < 100 && !mem_we; i++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("rstmid we seen", mem_we, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("rstmid outs", {mem_re, mem_we, mem_wdata, alu_A, alu_B, alu_Seletor}, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rstmid refetch", {mem_re, mem_we, mem_addr}, {1'b1, 1'b0, 8'h00});
    checkOutput("rstmid pc", pc, 8'h00);
    checkOutput("rstmid no write", mem[8'h40], 8'h55);
    for (int r = 0; r < 4; r++) begin
      readReg(r, v);
      checkOutput($sformatf("rstmid R%0d", r), v, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/redux_ctrl.md
Name: redux_ctrl

Overview:
- Multi-cycle control/sequencing unit for the Redux-V 8-bit core.
- It fetches and decodes instructions, owns the PC and a 4x8 register file, and drives the combinational ALU (operands A/B, 4-bit Seletor).
- It consumes the ALU's S/ZERO result and writes it back.
- It is the initiator on the ALU interface and the master on the single-port memory bus.

Parameters:
- RESET_PC, 8'h00: PC value loaded on reset.
- DATA_W, 8: datapath width. Fixed at 8; any other value is unsupported.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- alu_A  out  8  ALU operand A
- alu_B  out  8  ALU operand B
- alu_Seletor  out  4  ALU operation select
- alu_S  in  8  ALU result (combinational, valid same cycle)
- alu_ZERO  in  1  ALU zero flag (alu_S==0)
- mem_addr  out  8  memory address
- mem_re  out  1  read request
- mem_we  out  1  write request
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the current request this cycle
- pc  out  8  current PC
- halted  out  1  core is in HALT
- dbg_sel  in  2  register-file debug read select
- dbg_data  out  8  R[dbg_sel], combinational

Behaviour:
- Reset (synchronous): on a clock edge with reset=1:
  - state<=FETCH, PC<=RESET_PC, IR<=0, R0..R3<=0, halted<=0.
  - While reset=1, mem_re, mem_we, alu_A, alu_B, alu_Seletor and mem_wdata are all forced to 0.
  - Reset asserted in any state, including mid-memory-wait, aborts that operation; no register or memory write occurs in that cycle.
- Instruction format: IR[7:4]=op, IR[3:2]=ra, IR[1:0]=rb.
- Opcodes:
  - 0 to 9: ALU ops NOT, AND, OR, XOR, ADD, SUB, SLR, SRR, MUL, ROL; alu_Seletor=op.
  - 10 LD: R[ra]<=MEM[R[rb]]
  - 11 ST: MEM[R[rb]]<=R[ra]
  - 12 BRZR: if R[ra]==0 then PC<=R[rb]
  - 13 JI: PC<=PC_of_instr + sign-extended IR[3:0]
  - 14 LI: two-byte instruction, R[ra]<=next byte
  - 15 HALT
- States: FETCH, DECODE, EXEC, MEMRD, MEMWR, LIRD, HALT.
- FETCH:
  - mem_re=1, mem_addr=PC.
  - Holds while mem_ready=0.
  - On mem_ready=1: IR<=mem_rdata, PC<=PC+1 (mod 256), go DECODE.
- DECODE: one cycle; next state by op:
  - 0 to 9 and 12: EXEC
  - 10: MEMRD
  - 11: MEMWR
  - 13: FETCH, with PC<=PC-1+sext(IR[3:0])
  - 14: LIRD
  - 15: HALT
- EXEC:
  - ALU ops: alu_A=R[ra], alu_B=R[rb], alu_Seletor=op. On the edge, R[ra]<=alu_S. Go FETCH.
  - BRZR: alu_A=alu_B=R[ra], alu_Seletor=2 (OR). If alu_ZERO=1 then PC<=R[rb]. Go FETCH.
- MEMRD: mem_re=1, mem_addr=R[rb]; wait on mem_ready; on ready R[ra]<=mem_rdata, go FETCH.
- MEMWR: mem_we=1, mem_addr=R[rb], mem_wdata=R[ra]; wait on mem_ready; on ready go FETCH.
- LIRD: mem_re=1, mem_addr=PC; on ready R[ra]<=mem_rdata, PC<=PC+1, go FETCH.
- HALT: all requests 0, halted=1. Sticky until reset.
- Outside EXEC, alu_A, alu_B and alu_Seletor are 0.
- mem_re and mem_we are never both 1. The request, address and wdata are held stable until the cycle in which mem_ready=1.
- mem_ready=1 outside FETCH/MEMRD/MEMWR/LIRD is ignored.
- Latency with zero-wait memory:
  - ALU op / BRZR: 3 cycles
  - JI: 2 cycles
  - LD / ST / LI: 3 cycles
  - Each memory wait cycle adds 1.
- Arithmetic: PC wraps 8'hFF to 8'h00. ALU results are truncated to 8 bits by the ALU; the controller does no extension.
- Same-register cases:
  - ra==rb for LD: the address is read before write-back.
  - ra==rb for ALU ops: both operands are the same register.
- dbg_data reflects the register value after the most recent clock edge.

Test Plan:
- Mem: E0 08 E4 02 41 F0 (LI R0,8; LI R1,2; ADD R0,R1; HALT), zero-wait → in EXEC alu_A=8, alu_B=2, alu_Seletor=4; then R0=0x0A, R1=0x02, halted=1, pc=0x06.
- Same preload, then ALU ops 0 to 9 in turn (opcodes 00, 11, 21, ... 91 with R0 restored to 8 via LI before each) → Seletor equals opcode each EXEC; R0 receives alu_S from a reference ALU model.
- E0 05 50 E8 20 C2 F0 F0 (R0<=5, SUB R0,R0, R2<=0x20, BRZR R0,R2), mem[0x20]=F0 → alu_ZERO=1 in BRZR EXEC, pc jumps to 0x20, halts with pc=0x21.
- E4 40 E0 AA B1 A9 F0 (ST R0→[R1=0x40]; LD R2←[R1]) with mem_ready delayed 3 cycles per request → exactly one mem_we pulse train at addr 0x40 with wdata 0xAA held stable; R2=0xAA; no simultaneous mem_re/mem_we.
- JI backward: at 0x10 instruction DE (imm=-2) → next fetch addr 0x0E. At pc=0xFF a fetch wraps pc to 0x00.
- Assert reset for 1 cycle while in MEMWR waiting on mem_ready → no write, all outputs 0 that cycle, next cycle mem_re=1 with mem_addr=0x00, R0..R3=0.
